// File: rtl/uart_cmd_scheduler_pkg.sv
// Shared definitions for the UART command scheduler: opcodes, FSM states and
// status byte layout.
package uart_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_DIV_LO = 3'd1,
    OP_DIV_HI = 3'd2,
    OP_SEND   = 3'd3,
    OP_RECV   = 3'd4,
    OP_STATUS = 3'd5,
    OP_RESET  = 3'd6,
    OP_RSVD   = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_WAIT,
    ST_RX_WAIT,
    ST_RSP,
    ST_RST_PULSE
  } state_e;

  localparam int STAT_ERR = 7;
  localparam int STAT_TMO = 6;
  localparam int STAT_OVR = 5;

  // Bits 4:2 are reserved and always read as zero.
  function automatic logic [7:0] pack_status(input logic err, input logic tmo,
                                             input logic ovr, input logic [1:0] div_top);
    logic [7:0] s;
    s           = '0;
    s[STAT_ERR] = err;
    s[STAT_TMO] = tmo;
    s[STAT_OVR] = ovr;
    s[1:0]      = div_top;
    return s;
  endfunction

endpackage

// File: rtl/uart_sched_timeout.sv
// Loadable 16-bit down-counter; terminal is high while the count sits at zero.
module uart_sched_timeout (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        enable,
  output logic        terminal
);

  logic [15:0] count;

  assign terminal = (count == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !terminal) begin
      count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Command scheduler in front of a UART: programs the baud divisor, sends and
// receives single bytes, reports sticky status and requests a system reset.
module uart_cmd_scheduler
  import uart_cmd_scheduler_pkg::*;
#(
  parameter logic [11:0] DIV_RESET  = 12'd104,
  parameter logic [15:0] RX_TIMEOUT = 16'd50000,
  parameter int          RST_PULSE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [11:0] baud_div,
  output logic        baud_load,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  output logic        reset_strobe,
  output logic        busy
);

  // The timer counts the remaining cycles of the current wait state, so the
  // load values are one less than the number of cycles spent there.
  localparam logic [15:0] RX_LOAD  = RX_TIMEOUT - 16'd1;
  localparam logic [15:0] RST_LOAD = 16'(RST_PULSE - 1);

  state_e      state, next_state;
  cmd_op_e     op;
  logic        accept;
  logic [7:0]  div_lo_shadow;
  logic [11:0] new_div;
  logic        err, tmo, ovr;
  logic        rx_en;
  logic        timer_load, timer_enable, timer_terminal;
  logic [15:0] timer_load_value;

  assign op           = cmd_op_e'(cmd_op);
  assign accept       = cmd_valid && (state == ST_IDLE);
  assign new_div      = {cmd_data[3:0], div_lo_shadow};
  assign cmd_ready    = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign tx_valid     = (state == ST_TX_WAIT);
  assign rsp_valid    = (state == ST_RSP);
  assign reset_strobe = (state == ST_RST_PULSE);
  assign rx_ready     = rx_en;

  uart_sched_timeout u_timeout (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_enable),
    .terminal   (timer_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state       = state;
    timer_load       = 1'b0;
    timer_load_value = RX_LOAD;
    timer_enable     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_SEND:   next_state = ST_TX_WAIT;
            OP_STATUS: next_state = ST_RSP;
            OP_RECV: begin
              next_state = ST_RX_WAIT;
              timer_load = 1'b1;
            end
            OP_RESET: begin
              next_state       = ST_RST_PULSE;
              timer_load       = 1'b1;
              timer_load_value = RST_LOAD;
            end
            default: next_state = ST_IDLE;
          endcase
        end
      end
      ST_TX_WAIT: if (tx_ready) next_state = ST_IDLE;
      ST_RX_WAIT: begin
        timer_enable = 1'b1;
        if (rx_valid || timer_terminal) next_state = ST_RSP;
      end
      ST_RSP: if (rsp_ready) next_state = ST_IDLE;
      ST_RST_PULSE: begin
        timer_enable = 1'b1;
        if (timer_terminal) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A byte arriving in the same cycle as a STATUS read is a new event, so the
  // overrun set below is ordered after the clear and survives it.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div      <= DIV_RESET;
      baud_load     <= 1'b0;
      div_lo_shadow <= 8'd0;
      tx_data       <= 8'd0;
      rsp_data      <= 8'd0;
      err           <= 1'b0;
      tmo           <= 1'b0;
      ovr           <= 1'b0;
      rx_en         <= 1'b0;
    end else begin
      rx_en     <= 1'b1;
      baud_load <= 1'b0;
      if (accept) begin
        case (op)
          OP_DIV_LO: div_lo_shadow <= cmd_data;
          OP_DIV_HI: begin
            if (new_div != 12'd0) begin
              baud_div  <= new_div;
              baud_load <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          OP_SEND: tx_data <= cmd_data;
          OP_STATUS: begin
            rsp_data <= pack_status(err, tmo, ovr, baud_div[11:10]);
            err      <= 1'b0;
            tmo      <= 1'b0;
            ovr      <= 1'b0;
          end
          OP_RSVD: err <= 1'b1;
          default: ;
        endcase
      end
      if (state == ST_RX_WAIT) begin
        if (rx_valid) begin
          rsp_data <= rx_data;
        end else if (timer_terminal) begin
          rsp_data <= 8'h00;
          tmo      <= 1'b1;
        end
      end
      if (rx_valid && rx_en && (state != ST_RX_WAIT)) ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Randomized self-checking bench for uart_cmd_scheduler against a behavioural
// model of divisor, sticky flags and per-command latencies.
module tb_uart_cmd_scheduler;

  localparam logic [11:0] DIV_RST = 12'd104;
  localparam logic [15:0] RXT     = 16'd20;
  localparam int          RSTP    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic [11:0] baud_div;
  logic        baud_load;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
  logic        reset_strobe, busy;

  logic [11:0] m_baud;
  logic [7:0]  m_lo;
  logic        m_err, m_tmo, m_ovr;
  int          n_checks = 0;
  int          n_fail = 0;

  uart_cmd_scheduler #(
    .DIV_RESET  (DIV_RST),
    .RX_TIMEOUT (RXT),
    .RST_PULSE  (RSTP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .baud_div     (baud_div),
    .baud_load    (baud_load),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .reset_strobe (reset_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_baud = DIV_RST;
    m_lo   = 8'd0;
    m_err  = 1'b0;
    m_tmo  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_phase(input logic [7:0] exp);
    int stall;
    stall = $urandom_range(0, 3);
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_data", rsp_data, exp);
    for (int j = 0; j < stall; j++) begin
      tick();
      checkOutput("rsp_hold_valid", rsp_valid, 1);
      checkOutput("rsp_hold_data", rsp_data, exp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_done_busy", busy, 0);
  endtask

  task automatic do_div_hi(input logic [7:0] d);
    logic [11:0] nd;
    logic        exp_load;
    nd = {d[3:0], m_lo};
    exp_load = (nd != 12'd0);
    if (exp_load) m_baud = nd;
    else          m_err  = 1'b1;
    issue(3'd2, d);
    checkOutput("baud_load_pulse", baud_load, exp_load);
    checkOutput("baud_div", baud_div, m_baud);
    tick();
    checkOutput("baud_load_single", baud_load, 0);
  endtask

  task automatic do_send(input logic [7:0] d, input int stall);
    issue(3'd3, d);
    tx_ready = 1'b0;
    for (int j = 0; j < stall; j++) begin
      checkOutput("tx_hold_valid", tx_valid, 1);
      checkOutput("tx_hold_data", tx_data, d);
      tick();
    end
    checkOutput("tx_valid", tx_valid, 1);
    checkOutput("tx_data", tx_data, d);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput("tx_done_valid", tx_valid, 0);
    checkOutput("tx_done_busy", busy, 0);
  endtask

  // Byte offered in the k-th RX_WAIT cycle; k >= RXT means it never arrives.
  task automatic do_recv(input int k, input logic [7:0] b);
    int i;
    logic [7:0] exp;
    issue(3'd4, 8'($urandom));
    checkOutput("rx_ready_wait", rx_ready, 1);
    i = 0;
    while (!rsp_valid && i < int'(RXT) + 5) begin
      if (i == k) begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      tick();
      rx_valid = 1'b0;
      i++;
    end
    if (k < int'(RXT)) begin
      exp = b;
      checkOutput("recv_latency", i, k + 1);
    end else begin
      exp = 8'h00;
      m_tmo = 1'b1;
      checkOutput("tmo_latency", i, RXT);
    end
    rsp_phase(exp);
  endtask

  task automatic do_status();
    logic [7:0] exp;
    exp = {m_err, m_tmo, m_ovr, 3'b000, m_baud[11:10]};
    m_err = 1'b0;
    m_tmo = 1'b0;
    m_ovr = 1'b0;
    issue(3'd5, 8'($urandom));
    rsp_phase(exp);
  endtask

  task automatic do_reset_op();
    int n;
    issue(3'd6, 8'($urandom));
    n = 0;
    while (reset_strobe && n < 20) begin
      checkOutput("cmd_ready_in_pulse", cmd_ready, 0);
      tick();
      n++;
    end
    checkOutput("strobe_width", n, RSTP);
    checkOutput("strobe_done_busy", busy, 0);
  endtask

  task automatic inject_overrun();
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    tick();
    rx_valid = 1'b0;
    m_ovr = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] d);
    case (op)
      3'd0: begin
        issue(op, d);
        checkOutput("nop_busy", busy, 0);
        checkOutput("nop_baud", baud_div, m_baud);
      end
      3'd1: begin
        m_lo = d;
        issue(op, d);
        checkOutput("div_lo_baud", baud_div, m_baud);
        checkOutput("div_lo_load", baud_load, 0);
      end
      3'd2: do_div_hi(d);
      3'd3: do_send(d, $urandom_range(0, 6));
      3'd4: do_recv($urandom_range(0, int'(RXT) + 2), 8'($urandom));
      3'd5: do_status();
      3'd6: do_reset_op();
      default: begin
        m_err = 1'b1;
        issue(op, d);
        checkOutput("rsvd_busy", busy, 0);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; rsp_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_rx_ready", rx_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_baud_load", baud_load, 0);
    checkOutput("rst_strobe", reset_strobe, 0);
    checkOutput("rst_baud_div", baud_div, DIV_RST);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    tick();
    checkOutput("rx_ready_after_rst", rx_ready, 1);

    applyStimulus(3'd1, 8'h34);
    applyStimulus(3'd2, 8'hF2);
    checkOutput("div_0x234", baud_div, 12'h234);
    do_send(8'hA5, 5);
    do_recv(9, 8'h5C);
    do_recv(int'(RXT) - 1, 8'h77);
    do_status();
    do_recv(int'(RXT) + 3, 8'h00);
    do_status();
    do_status();
    applyStimulus(3'd1, 8'h00);
    applyStimulus(3'd2, 8'hA0);
    applyStimulus(3'd7, 8'h00);
    inject_overrun();
    do_status();
    do_reset_op();

    repeat (80) begin
      if ($urandom_range(0, 7) == 0) inject_overrun();
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom));
    end
    do_status();

    applyStimulus(3'd1, 8'h99);
    applyStimulus(3'd2, 8'h07);
    issue(3'd3, 8'h3C);
    tx_ready = 1'b0;
    tick();
    checkOutput("pre_abort_tx_valid", tx_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checkOutput("abort_tx_valid", tx_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_baud_div", baud_div, DIV_RST);
    checkOutput("abort_tx_data", tx_data, 0);
    tick();
    do_status();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
